isp_demosaic_bilinear: RTL and testbench

Streaming bilinear demosaic stage that sits directly downstream of the white-balance stage. It consumes the gain-corrected Bayer raw stream (B at even row / even col, R at odd row / odd col, G elsewhere) and produces one full RGB pixel per accepted raw pixel. A 3x3 window is built from two line buffers and a column shift register, with mirrored borders. The output stream is the input raster delayed by exactly WIDTH+1 accepted pixels.

---
 rtl/isp_demosaic_bilinear.sv | 144 ++++++++++++++
 tb/tb_isp_demosaic_bilinear.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/isp_demosaic_bilinear.sv
// Streaming bilinear Bayer demosaic: two line buffers plus a 3x3 window with mirrored borders.
// Output is the input raster delayed by WIDTH+1 accepts, registered three cycles after the accept.
module isp_demosaic_bilinear #(
  parameter int BITS   = 8,
  parameter int WIDTH  = 1936,
  parameter int HEIGHT = 1088
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            data_valid,
  input  logic [BITS-1:0] in_raw,
  output logic            out_valid,
  output logic [BITS-1:0] out_r,
  output logic [BITS-1:0] out_g,
  output logic [BITS-1:0] out_b
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int PW = $clog2(WIDTH + 2);
  localparam int SW = BITS + 2;

  logic [CW-1:0]   col, ccol, s1_ccol;
  logic [RW-1:0]   row, crow, s1_crow;
  logic [PW-1:0]   prime;
  logic            primed, produce;
  logic [3:1]      vld_pipe;

  logic [BITS-1:0] lb1 [WIDTH];
  logic [BITS-1:0] lb2 [WIDTH];
  logic [BITS-1:0] win [3][3];
  logic [BITS-1:0] cm  [3][3];
  logic [BITS-1:0] m   [3][3];

  logic [SW-1:0]   h, v, d;
  logic [BITS-1:0] s2_c;
  logic [SW-1:0]   s2_h, s2_v, s2_x, s2_d;
  logic [1:0]      s2_site;
  logic [BITS-1:0] nr, ng, nb;

  assign primed    = (prime == PW'(WIDTH + 1));
  assign produce   = data_valid & primed;
  assign out_valid = vld_pipe[3];

  // Input raster, centre raster and priming counters.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      row      <= '0;
      ccol     <= '0;
      crow     <= '0;
      s1_ccol  <= '0;
      s1_crow  <= '0;
      prime    <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[2:1], produce};
      if (data_valid) begin
        if (col == CW'(WIDTH - 1)) begin
          col <= '0;
          row <= (row == RW'(HEIGHT - 1)) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (!primed) prime <= prime + PW'(1);
        if (primed) begin
          s1_ccol <= ccol;
          s1_crow <= crow;
          if (ccol == CW'(WIDTH - 1)) begin
            ccol <= '0;
            crow <= (crow == RW'(HEIGHT - 1)) ? '0 : crow + RW'(1);
          end else begin
            ccol <= ccol + CW'(1);
          end
        end
      end
    end
  end

  // Line buffers and window hold pixel data only; their contents need no reset.
  always_ff @(posedge pclk) begin
    if (data_valid) begin
      lb1[col] <= in_raw;
      lb2[col] <= lb1[col];
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb2[col];
      win[1][2] <= lb1[col];
      win[2][2] <= in_raw;
    end
  end

  // Column mirror first, then row mirror, so corners get both.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      cm[r][0] = (s1_ccol == '0) ? win[r][2] : win[r][0];
      cm[r][1] = win[r][1];
      cm[r][2] = (s1_ccol == CW'(WIDTH - 1)) ? win[r][0] : win[r][2];
    end
    for (int c = 0; c < 3; c++) begin
      m[0][c] = (s1_crow == '0) ? cm[2][c] : cm[0][c];
      m[1][c] = cm[1][c];
      m[2][c] = (s1_crow == RW'(HEIGHT - 1)) ? cm[0][c] : cm[2][c];
    end
  end

  assign h = SW'(m[1][0]) + SW'(m[1][2]);
  assign v = SW'(m[0][1]) + SW'(m[2][1]);
  assign d = SW'(m[0][0]) + SW'(m[0][2]) + SW'(m[2][0]) + SW'(m[2][2]);

  always_ff @(posedge pclk) begin
    s2_c    <= m[1][1];
    s2_h    <= h;
    s2_v    <= v;
    s2_x    <= h + v;
    s2_d    <= d;
    s2_site <= {s1_crow[0], s1_ccol[0]};
  end

  always_comb begin
    nr = s2_c;
    ng = s2_c;
    nb = s2_c;
    case (s2_site)
      2'b00: begin nb = s2_c; ng = BITS'(s2_x >> 2); nr = BITS'(s2_d >> 2); end
      2'b01: begin ng = s2_c; nb = BITS'(s2_h >> 1); nr = BITS'(s2_v >> 1); end
      2'b10: begin ng = s2_c; nr = BITS'(s2_h >> 1); nb = BITS'(s2_v >> 1); end
      default: begin nr = s2_c; ng = BITS'(s2_x >> 2); nb = BITS'(s2_d >> 2); end
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      out_r <= '0;
      out_g <= '0;
      out_b <= '0;
    end else if (vld_pipe[2]) begin
      out_r <= nr;
      out_g <= ng;
      out_b <= nb;
    end
  end
endmodule

// File: tb/tb_isp_demosaic_bilinear.sv
// Bench for isp_demosaic_bilinear on an 8x4 frame: hand-computed vector table, a mirrored-border
// reference model for random frames, gappy input, latency tracking and mid-frame reset.
module tb_isp_demosaic_bilinear;
  localparam int W = 8, H = 4, WH = W * H;

  logic       pclk = 0, rst_n = 0, data_valid = 0;
  logic [7:0] in_raw = 0;
  logic       out_valid;
  logic [7:0] out_r, out_g, out_b;

  isp_demosaic_bilinear #(.BITS(8), .WIDTH(W), .HEIGHT(H)) dut (
    .pclk(pclk), .rst_n(rst_n), .data_valid(data_valid), .in_raw(in_raw),
    .out_valid(out_valid), .out_r(out_r), .out_g(out_g), .out_b(out_b));

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc++;

  int          total = 0, bad = 0, acc_cnt = 0;
  int          exp_cyc[$];
  int          pix_q[$];
  logic [23:0] got_q[$];
  logic [23:0] cont[64];
  logic [7:0]  rnd[73];

  typedef struct {
    string name;
    int    pat, r, c;
    int    er, eg, eb;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge pclk) begin
    if (rst_n && out_valid) begin
      got_q.push_back({out_r, out_g, out_b});
      if (exp_cyc.size() == 0) chk("out_unexpected", 0, 1);
      else chk("latency", cyc, exp_cyc.pop_front());
    end
  end

  task automatic flush();
    exp_cyc.delete();
    got_q.delete();
    pix_q.delete();
    acc_cnt = 0;
  endtask

  task automatic do_reset();
    @(posedge pclk); #1;
    rst_n = 0;
    data_valid = 0;
    flush();
    repeat (2) @(posedge pclk);
    #1 rst_n = 1;
  endtask

  task automatic drive(input logic vin, input logic [7:0] din);
    @(posedge pclk); #1;
    data_valid = vin;
    in_raw = din;
    if (vin) begin
      pix_q.push_back(int'(din));
      if (acc_cnt >= W + 1) exp_cyc.push_back(cyc + 3);
      acc_cnt++;
    end
  endtask

  task automatic drain();
    drive(0, 8'd0);
    repeat (5) @(posedge pclk);
    chk("drain_pending", exp_cyc.size(), 0);
  endtask

  function automatic int pat_val(input int p, input int r, input int c);
    case (p)
      0: return 100;
      1: return (r % 2 == 0 && c % 2 == 0) ? 40 : (r % 2 == 1 && c % 2 == 1) ? 160 : 80;
      2: return 255;
      default: return (r == 2 && c == 2) ? 10 : (r == 2 && c == 4) ? 11 : 20;
    endcase
  endfunction

  task automatic send_frames(input int p, input int nf);
    for (int f = 0; f < nf; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) drive(1, 8'(pat_val(p, r, c)));
  endtask

  function automatic int px(input int base, input int r, input int c);
    int rr, cc;
    rr = (r < 0) ? 1 : (r >= H) ? H - 2 : r;
    cc = (c < 0) ? 1 : (c >= W) ? W - 2 : c;
    return pix_q[base + rr * W + cc];
  endfunction

  function automatic logic [23:0] model(input int k);
    int base, r, c, cc, n, s, wv, e, ds, rr, gg, bb;
    base = (k / WH) * WH;
    r = (k % WH) / W;
    c = k % W;
    cc = px(base, r, c);
    n = px(base, r - 1, c);
    s = px(base, r + 1, c);
    wv = px(base, r, c - 1);
    e = px(base, r, c + 1);
    ds = px(base, r - 1, c - 1) + px(base, r - 1, c + 1) + px(base, r + 1, c - 1) + px(base, r + 1, c + 1);
    case ((r % 2) * 2 + (c % 2))
      0: begin bb = cc; gg = (n + s + wv + e) / 4; rr = ds / 4; end
      1: begin gg = cc; bb = (wv + e) / 2; rr = (n + s) / 2; end
      2: begin gg = cc; rr = (wv + e) / 2; bb = (n + s) / 2; end
      default: begin rr = cc; gg = (n + s + wv + e) / 4; bb = ds / 4; end
    endcase
    return 24'((rr << 16) | (gg << 8) | bb);
  endfunction

  initial begin
    tbl[0]  = '{"flat_0_0",   0, 0, 0, 100, 100, 100};
    tbl[1]  = '{"flat_2_5",   0, 2, 5, 100, 100, 100};
    tbl[2]  = '{"flat_3_7",   0, 3, 7, 100, 100, 100};
    tbl[3]  = '{"field_0_0",  1, 0, 0, 160, 80, 40};
    tbl[4]  = '{"field_0_7",  1, 0, 7, 160, 80, 40};
    tbl[5]  = '{"field_3_0",  1, 3, 0, 160, 80, 40};
    tbl[6]  = '{"field_3_7",  1, 3, 7, 160, 80, 40};
    tbl[7]  = '{"field_1_4",  1, 1, 4, 160, 80, 40};
    tbl[8]  = '{"field_2_3",  1, 2, 3, 160, 80, 40};
    tbl[9]  = '{"max_0_0",    2, 0, 0, 255, 255, 255};
    tbl[10] = '{"max_1_1",    2, 1, 1, 255, 255, 255};
    tbl[11] = '{"max_3_7",    2, 3, 7, 255, 255, 255};
    tbl[12] = '{"round_2_3",  3, 2, 3, 20, 20, 10};
    tbl[13] = '{"round_2_2",  3, 2, 2, 20, 20, 10};
    tbl[14] = '{"round_2_4",  3, 2, 4, 20, 20, 11};
    tbl[15] = '{"trunc_1_3",  3, 1, 3, 20, 20, 15};
    tbl[16] = '{"bottom_3_3", 3, 3, 3, 20, 20, 10};
    for (int i = 0; i < 73; i++) rnd[i] = 8'($urandom_range(255, 0));

    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_rgb", {out_r, out_g, out_b}, 0);
    repeat (2) @(posedge pclk);
    #1 rst_n = 1;

    for (int i = 0; i < 17; i++) begin
      int idx;
      do_reset();
      send_frames(tbl[i].pat, 2);
      drain();
      idx = tbl[i].r * W + tbl[i].c;
      if (got_q.size() > idx)
        chk(tbl[i].name, int'(got_q[idx]), (tbl[i].er << 16) | (tbl[i].eg << 8) | tbl[i].eb);
      else
        chk({tbl[i].name, "_missing"}, got_q.size(), idx + 1);
    end

    // Flat, three continuous frames: output count and every value.
    do_reset();
    send_frames(0, 3);
    drain();
    chk("flat_count", got_q.size(), 3 * WH - (W + 1));
    for (int k = 0; k < got_q.size(); k++) chk("flat_val", int'(got_q[k]), 24'h646464);

    // Random frames, contiguous, against the reference model.
    do_reset();
    for (int i = 0; i < 73; i++) drive(1, rnd[i]);
    drain();
    chk("rand_count", got_q.size(), 64);
    for (int k = 0; k < 64 && k < got_q.size(); k++) begin
      chk("rand_model", int'(got_q[k]), int'(model(k)));
      cont[k] = got_q[k];
    end

    // Same data with random gaps must give the same sequence.
    do_reset();
    for (int i = 0; i < 73; i++) begin
      if ($urandom_range(1, 0) == 1) drive(0, 8'hAA);
      drive(1, rnd[i]);
    end
    drain();
    chk("gap_count", got_q.size(), 64);
    for (int k = 0; k < 64 && k < got_q.size(); k++) chk("gap_seq", int'(got_q[k]), int'(cont[k]));

    // Reset asserted while pixel (2,3) is on the input.
    do_reset();
    for (int i = 0; i < 19; i++) drive(1, rnd[72 - i]);
    @(posedge pclk); #1;
    chk("pre_rst_valid", out_valid, 1);
    #1 rst_n = 0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_rgb", {out_r, out_g, out_b}, 0);
    data_valid = 0;
    flush();
    repeat (2) @(posedge pclk);
    #1 rst_n = 1;
    for (int i = 0; i < 73; i++) drive(1, rnd[i]);
    drain();
    chk("restart_count", got_q.size(), 64);
    for (int k = 0; k < 64 && k < got_q.size(); k++) chk("restart_model", int'(got_q[k]), int'(model(k)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
